// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bus.
// Groups the pipeline-side hazard inputs and the sequencing outputs that
// run between the core datapath and hazard_stall_ctrl.
//   master : pipeline side (drives ID/EX/MEM hazard info, receives enables)
//   slave  : controller side (receives hazard info, drives enables/counters)
// Ports:
//   id_opcode/id_rs1/id_rs2        instruction currently in ID
//   exe_rd/exe_regwrite/exe_memread instruction currently in EX
//   mem_rd/mem_memread              instruction currently in MEM
//   id_branch_taken                 ID-stage branch/jump resolved taken
//   dmem_busy                       data memory cannot finish this cycle
//   pc_write/ifid_write/idex_bubble/ifid_flush/pipe_freeze  pipeline controls
//   stall_cnt/flush_cnt             saturating performance counters
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       exe_rd;
    logic             exe_regwrite;
    logic             exe_memread;
    logic [4:0]       mem_rd;
    logic             mem_memread;
    logic             id_branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_opcode, id_rs1, id_rs2, exe_rd, exe_regwrite, exe_memread,
               mem_rd, mem_memread, id_branch_taken, dmem_busy,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, exe_rd, exe_regwrite, exe_memread,
               mem_rd, mem_memread, id_branch_taken, dmem_busy,
        output pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Detects load-use hazards and ID-resolved branch/JALR operand hazards that
// forwarding cannot cover, inserts bubbles, flushes IF/ID on taken branches
// and freezes the back end while data memory is busy.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  hazard_stall_ctrl_if.slave (hazard inputs, control outputs, counters)
//
// state   | meaning
// RUN     | normal issue; hazards evaluated every cycle
// STALL   | second cycle of a 2-cycle load->branch stall (rem holds remaining)
// MEMWAIT | back end frozen on dmem_busy; ret_stall/rem remember where to go
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;

    typedef enum logic [1:0] {RUN, STALL, MEMWAIT} state_t;

    state_t           state, state_nxt, eff_state;
    logic             ret_stall, ret_stall_nxt;
    logic [1:0]       rem, rem_nxt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;

    logic use_rs1, use_rs2, id_resolved;
    logic exe_hit, mem_hit;
    logic need_two, need_one;

    logic pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze;

    // x0 sources never match, so a zero rd can never produce a hit.
    assign use_rs1     = !(bus.id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign use_rs2     = use_rs1 && !(bus.id_opcode inside {OP_LOAD, OP_IALU, OP_JALR});
    assign id_resolved = (bus.id_opcode == OP_BRANCH) || (bus.id_opcode == OP_JALR);

    assign exe_hit = (bus.exe_rd != 5'd0) &&
                     ((use_rs1 && bus.exe_rd == bus.id_rs1) ||
                      (use_rs2 && bus.exe_rd == bus.id_rs2));
    assign mem_hit = (bus.mem_rd != 5'd0) &&
                     ((use_rs1 && bus.mem_rd == bus.id_rs1) ||
                      (use_rs2 && bus.mem_rd == bus.id_rs2));

    assign need_two = id_resolved && bus.exe_memread && exe_hit;
    assign need_one = (bus.exe_memread && exe_hit) ||
                      (id_resolved && bus.exe_regwrite && exe_hit) ||
                      (id_resolved && bus.mem_memread && mem_hit);

    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        ret_stall_nxt = ret_stall;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        pipe_freeze   = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        // Leaving MEMWAIT behaves exactly like the saved state in that cycle.
        eff_state = state;
        if (state == MEMWAIT && !bus.dmem_busy)
            eff_state = ret_stall ? STALL : RUN;

        if (bus.dmem_busy) begin
            pipe_freeze = 1'b1;
            state_nxt   = MEMWAIT;
            if (state != MEMWAIT)
                ret_stall_nxt = (state == STALL);
        end else begin
            case (eff_state)
                STALL: begin
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    rem_nxt     = rem - 2'd1;
                    state_nxt   = (rem <= 2'd1) ? RUN : STALL;
                end
                default: begin
                    state_nxt = RUN;
                    if (need_two) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        rem_nxt     = 2'd1;
                        state_nxt   = STALL;
                    end else if (need_one) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = bus.id_branch_taken;
                        flush_inc  = bus.id_branch_taken;
                    end
                end
            endcase
        end

        // Reset drives a safe "bubble + flush, no advance" pattern.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            rem         <= 2'd0;
            ret_stall   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            ret_stall <= ret_stall_nxt;
            if (stall_inc && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.pipe_freeze = pipe_freeze;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Detects load-use and ID-stage branch/JALR operand hazards that forwarding cannot cover.
- Drives PC/IF-ID write enables, ID/EX bubble insertion, the IF/ID flush on taken branches, and a global freeze during data-memory wait.
- Sits beside the forwarding unit. Keeps per-event saturating performance counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
id_opcode  in  7  opcode of the instruction in ID
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
exe_rd  in  5  rd of the instruction in EX
exe_regwrite  in  1  EX instruction writes rd
exe_memread  in  1  EX instruction is a load
mem_rd  in  5  rd of the instruction in MEM
mem_memread  in  1  MEM instruction is a load
id_branch_taken  in  1  ID-stage branch/jump resolved taken
dmem_busy  in  1  data memory cannot complete the MEM access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register write enable
idex_bubble  out  1  load NOP (all control zero) into ID/EX
ifid_flush  out  1  clear IF/ID to NOP
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB unchanged
stall_cnt  out  CNT_W  count of hazard-stall cycles, saturating
flush_cnt  out  CNT_W  count of flushes, saturating

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Operand usage:
  - rs1 is unused for LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is unused for those three and for loads 0000011, I-ALU 0010011 and JALR 1100111.
  - An unused or x0 source never matches.
- ID-resolved class: branch 1100011 or JALR 1100111.
- Required stall N, evaluated in RUN, first matching rule wins:
  - ID-resolved and exe_memread and exe_rd matches a used source -> N=2.
  - exe_memread and exe_rd matches a used source (any class) -> N=1.
  - ID-resolved and exe_regwrite and exe_rd matches -> N=1.
  - ID-resolved and mem_memread and mem_rd matches -> N=1.
  - Otherwise N=0.
- States: RUN, STALL, MEMWAIT. A 2-bit remaining counter rem, held in a register.
- RUN:
  - If dmem_busy: go to MEMWAIT; assert pipe_freeze=1, pc_write=0, ifid_write=0; no hazard action this cycle.
  - Else if N>0: pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt+1. If N=2: rem<=1, go to STALL. If N=1: stay in RUN and re-evaluate next cycle.
  - Else: pc_write=1, ifid_write=1. If id_branch_taken: ifid_flush=1 and flush_cnt+1.
- STALL:
  - pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt+1. rem decrements; at rem=0 go to RUN.
  - id_branch_taken is ignored (operands are not valid).
  - If dmem_busy: freeze takes priority. Go to MEMWAIT, with rem and the return state saved. No bubble and no stall_cnt increment in that cycle.
- MEMWAIT:
  - pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
  - Stays while dmem_busy=1.
  - On the first cycle with dmem_busy=0: return to the saved state (RUN or STALL, rem intact). Outputs that cycle are those of the returned-to state, evaluated combinationally.
- Defaults: pipe_freeze=0, idex_bubble=0, ifid_flush=0 unless stated above.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones, with no wrap.
- Reset:
  - While rst=1: state RUN, rem=0, both counters 0, saved state RUN.
  - Outputs are forced to pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, pipe_freeze=0.
  - Reset mid-STALL or mid-MEMWAIT abandons the stall immediately.
- All outputs other than the counters are combinational from state, rem and inputs. Detection adds zero latency.

Test Plan:
- EX=lw x5 (exe_memread=1, exe_rd=5); ID=add x6,x5,x7 (opcode 0110011) -> 1 cycle with pc_write=0, idex_bubble=1; next cycle (inputs cleared) pc_write=1; stall_cnt=1.
- EX=lw x5; ID=beq x5,x0 -> 2 stall cycles (RUN then STALL), stall_cnt=2. Then EX=add x5 with ID=beq x5 -> 1 stall. Also ID=addi x6,x1 (opcode 0010011) with id_rs2=5 -> no stall, since rs2 is unused.
- EX writes x0 via load (exe_rd=0); ID=add x1,x0,x0 -> no stall. Separately, id_branch_taken=1 in RUN with no hazard -> ifid_flush=1 for 1 cycle, flush_cnt=1.
- During STALL (rem=1), raise dmem_busy for 3 cycles -> pipe_freeze=1 for 3 cycles, stall_cnt unchanged; after release, 1 STALL cycle completes, then RUN.
- Assert rst mid-STALL -> outputs immediately 0/0/1/1/0 (pc_write/ifid_write/idex_bubble/ifid_flush/pipe_freeze), counters 0; after release, state RUN.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_cnt holds at 15.
